serial_subtractor_8bit: RTL and testbench
=========================================

// Module: serial_subtractor_8bit
// PURPOSE
//  Bit-serial WIDTH-bit subtractor: DIFF = A - B (two's complement).
//  Reuses one full-adder cell per cycle: A + ~B + 1, with a registered carry (borrow) bit.
//  Processes operands LSB first, one bit per clock, under a start/busy/done handshake.
//  Inverse operation to the parallel ripple adder; serves as a datapath unit wherever area beats latency.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk         in   1      system clock, rising-edge
//  rst         in   1      asynchronous reset, active-high
//  start       in   1      request; sampled only in IDLE
//  a           in   WIDTH  minuend, captured on accepted start
//  b           in   WIDTH  subtrahend, captured on accepted start
//  busy        out  1      high while bits are being processed (state SHIFT)
//  done        out  1      one-cycle pulse: result valid (state DONE)
//  diff        out  WIDTH  A - B mod 2^WIDTH; held until next accepted start
//  borrow_out  out  1      1 when A < B unsigned (= NOT final carry)
//  overflow    out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-operation): state=IDLE; busy=done=0;
//    diff=0, borrow_out=0, overflow=0; operand shift regs, bit counter, carry=0. Partial result discarded.
//  - All outputs are registered; no combinational path from inputs to outputs.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE : start=1 at edge E0 -> load sa=a, sb=~b, carry=1, cnt=0; go SHIFT; busy=1.
//           start=0 -> stay; outputs hold.
//    SHIFT: each edge: s = sa[0]^sb[0]^carry; carry = maj(sa[0],sb[0],carry);
//           result shifts right with s into MSB; sa, sb shift right; cnt++.
//           On the WIDTH-th SHIFT edge (E0+WIDTH): diff<=final result, borrow_out<=~carry_next,
//           overflow computed from captured a/b MSBs and the new diff MSB; go DONE; busy=0, done=1.
//    DONE : exactly one cycle; next edge -> IDLE, done=0.
//  - Latency: done high in the cycle after edge E0+WIDTH; 8 cycles of busy at WIDTH=8.
//  - start while SHIFT or DONE: ignored (not queued). Earliest re-accept: first IDLE cycle,
//    i.e. one idle cycle between done pulse and next accepted start.
//  - a, b may change freely after capture; captured copies only are used.
//  - cnt is ceil(log2(WIDTH+1)) bits; no wrap occurs within an operation.
//  - Internal result register is updated only at completion; diff never shows partial values.
// TESTING
//  1 a=0x37,b=0x12, start 1 cycle -> busy 8 cycles, done pulse 1 cycle; diff=0x25, borrow_out=0, overflow=0.
//  2 a=0x12,b=0x37 -> diff=0xDB, borrow_out=1, overflow=0.
//  3 a=0x80,b=0x01 -> diff=0x7F, borrow_out=0, overflow=1; a=0x7F,b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
//  4 a=0x00,b=0x00 -> diff=0x00, borrow_out=0; a=0xFF,b=0xFF -> diff=0x00, borrow_out=0.
//  5 start held high continuously with a=0x10,b=0x01 then a=0x05 changed mid-op -> first result 0x0F;
//    second operation accepted only after DONE->IDLE; no extra done pulses.
//  6 assert rst at SHIFT cycle 4 -> all outputs 0 immediately (async); after release, a=0x09,b=0x03 -> diff=0x06.
//  Bench: self-checking vs. behavioural (a-b) model over 1000 random pairs; check done exactly 1 cycle wide.

Source files
------------

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial two's-complement subtractor: diff = a - b, computed LSB first as a + ~b + 1
// through a single full-adder cell with a registered carry, under a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SHIFT | one operand bit per clock, WIDTH clocks
// DONE  | one-cycle result-valid pulse
module serial_subtractor_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             a_msb, b_msb;

  logic             s_bit, carry_nxt, last_bit;
  logic [WIDTH-1:0] res_nxt;

  // single full-adder cell shared across all bit positions
  always_comb begin
    s_bit     = sa[0] ^ sb[0] ^ carry;
    carry_nxt = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    res_nxt   = {s_bit, res[WIDTH-1:1]};
    last_bit  = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= ~b;
            carry <= 1'b1;
            cnt   <= '0;
            res   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= carry_nxt;
          res   <= res_nxt;
          cnt   <= cnt + CW'(1);
          // diff is only written here so it never exposes a partial result
          if (last_bit) begin
            diff       <= res_nxt;
            borrow_out <= ~carry_nxt;
            overflow   <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Self-checking bench for serial_subtractor_8bit: directed vectors, held start, mid-op reset,
// and random operand pairs checked against plain a-b arithmetic.
module tb_serial_subtractor_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, borrow_out, overflow;
  logic [7:0] diff;

  int checks = 0;
  int failures = 0;

  serial_subtractor_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // one full operation from the earliest accept point, checked against the arithmetic model
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input string tag);
    int         busy_cycles;
    int         sd;
    logic [7:0] exp_diff;
    logic       exp_borrow, exp_ovf;
    exp_diff   = 8'(int'(ta) - int'(tbv));
    exp_borrow = (int'(ta) < int'(tbv));
    sd         = int'($signed(ta)) - int'($signed(tbv));
    exp_ovf    = (sd > 127) || (sd < -128);

    @(negedge clk);
    a = ta; b = tbv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL %s accept busy: got %b want 1", tag, busy);
    end
    busy_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1) break;
      busy_cycles++;
    end
    checks++;
    if (busy_cycles != 8) begin
      failures++; $display("FAIL %s busy_len: got %0d want 8", tag, busy_cycles);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL %s done_high: got %b want 1", tag, done);
    end
    checks++;
    if (diff !== exp_diff || borrow_out !== exp_borrow || overflow !== exp_ovf) begin
      failures++;
      $display("FAIL %s result a=%h b=%h: got diff=%h bo=%b ov=%b want diff=%h bo=%b ov=%b",
               tag, ta, tbv, diff, borrow_out, overflow, exp_diff, exp_borrow, exp_ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s done_width: got done=%b busy=%b want 0 0", tag, done, busy);
    end
    checks++;
    if (diff !== exp_diff) begin
      failures++; $display("FAIL %s diff_hold: got %h want %h", tag, diff, exp_diff);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, diff, borrow_out, overflow} !== 12'h000) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b diff=%h bo=%b ov=%b want all 0",
               busy, done, diff, borrow_out, overflow);
    end
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || diff !== 8'h00) begin
      failures++; $display("FAIL reset_hold: got busy=%b diff=%h want 0 00", busy, diff);
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    do_op(8'h37, 8'h12, "dir_37_12");
    do_op(8'h12, 8'h37, "dir_12_37");
    do_op(8'h80, 8'h01, "dir_80_01");
    do_op(8'h7F, 8'hFF, "dir_7f_ff");
    do_op(8'h00, 8'h00, "dir_00_00");
    do_op(8'hFF, 8'hFF, "dir_ff_ff");
  endtask

  task automatic test_start_held();
    logic exp_busy, exp_done;
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k == 0) a = 8'h05;
      if (k == 18) start = 1'b0;
      exp_busy = (k <= 7) || (k >= 10 && k <= 17);
      exp_done = (k == 8) || (k == 18);
      checks++;
      if (busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("FAIL held_hs k=%0d: got busy=%b done=%b want busy=%b done=%b",
                 k, busy, done, exp_busy, exp_done);
      end
      if (k == 8 || k == 17) begin
        checks++;
        if (diff !== 8'h0F) begin
          failures++; $display("FAIL held_first k=%0d: got %h want 0f", k, diff);
        end
      end
      if (k == 18) begin
        checks++;
        if (diff !== 8'h04) begin
          failures++; $display("FAIL held_second: got %h want 04", diff);
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL held_release: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 8'h55; b = 8'h22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, diff, borrow_out, overflow} !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b done=%b diff=%h bo=%b ov=%b want all 0",
               busy, done, diff, borrow_out, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_mid_idle: got busy=%b done=%b want 0 0", busy, done);
    end
    do_op(8'h09, 8'h03, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 1000; n++)
      do_op(8'($urandom), 8'($urandom), "random");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
